// File: rtl/ctrl_mc.sv
// Multicycle control unit for the RV32 subset CPU: fetch/decode/execute sequencing,
// loads/stores, BEQ/BNE, JAL, optional M-extension, and illegal/bus-timeout traps.
module ctrl_mc #(
    parameter int ALU_OP_W        = 8,
    parameter int HAS_M           = 1,
    parameter int MEM_TIMEOUT     = 15,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instr,
    input  logic                ram_ready,
    input  logic                alu_zero,
    output logic                ram_cs,
    output logic                ram_we,
    output logic                ram_oe,
    output logic                pc_en,
    output logic [1:0]          pc_in_dir,
    output logic                pc_sign,
    output logic                ir_en,
    output logic                reg_en,
    output logic                reg_we,
    output logic [1:0]          reg_in_dir,
    output logic                alu_en,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          op2_dir,
    output logic                trap,
    output logic [1:0]          trap_cause
);

    localparam logic [3:0] S_PREPARE = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_EXEC    = 4'd3;
    localparam logic [3:0] S_WB      = 4'd4;
    localparam logic [3:0] S_ADDR    = 4'd5;
    localparam logic [3:0] S_MEM     = 4'd6;
    localparam logic [3:0] S_MEMWB   = 4'd7;
    localparam logic [3:0] S_BR      = 4'd8;
    localparam logic [3:0] S_BRDONE  = 4'd9;
    localparam logic [3:0] S_JAL     = 4'd10;
    localparam logic [3:0] S_TRAP    = 4'd11;

    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_ADDI = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_DIV  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(10);
    localparam logic [ALU_OP_W-1:0] OP_LUI  = ALU_OP_W'(11);

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [3:0]          state_q, state_d;
    logic [CNT_W-1:0]    wait_q, wait_d;
    logic                trap_q, trap_d;
    logic [1:0]          cause_q, cause_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [1:0]          op2_q, op2_d;
    logic                store_q, store_d;
    logic                bne_q, bne_d;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic                dec_ok;
    logic [3:0]          dec_state;
    logic [ALU_OP_W-1:0] dec_op;
    logic [1:0]          dec_op2;
    logic                dec_store;
    logic                dec_bne;
    logic                timeout_hit;
    logic                unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign unused_instr = ^{instr[24:15], instr[11:7]};
    assign timeout_hit  = (MEM_TIMEOUT > 0) && (wait_q == WAIT_LIMIT);

    always_comb begin
        dec_ok    = 1'b0;
        dec_state = S_FETCH;
        dec_op    = OP_ADD;
        dec_op2   = 2'b00;
        dec_store = 1'b0;
        dec_bne   = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_state = S_EXEC;
                if (funct7 == 7'b0000000) begin
                    dec_ok = 1'b1;
                    case (funct3)
                        3'b000:  dec_op = OP_ADD;
                        3'b001:  dec_op = OP_SLL;
                        3'b101:  dec_op = OP_SRL;
                        3'b110:  dec_op = OP_OR;
                        3'b111:  dec_op = OP_AND;
                        3'b100:  dec_op = OP_XOR;
                        default: dec_ok = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_ok = 1'b1;
                    dec_op = OP_SUB;
                end else if (funct7 == 7'b0000001 && HAS_M != 0) begin
                    if (funct3 == 3'b000) begin
                        dec_ok = 1'b1;
                        dec_op = OP_MUL;
                    end else if (funct3 == 3'b100) begin
                        dec_ok = 1'b1;
                        dec_op = OP_DIV;
                    end
                end
            end
            7'b0010011: begin
                dec_ok    = (funct3 == 3'b000);
                dec_state = S_EXEC;
                dec_op    = OP_ADDI;
                dec_op2   = 2'b10;
            end
            7'b0110111: begin
                dec_ok    = 1'b1;
                dec_state = S_EXEC;
                dec_op    = OP_LUI;
                dec_op2   = 2'b01;
            end
            7'b0000011: begin
                dec_ok    = (funct3 == 3'b010);
                dec_state = S_ADDR;
                dec_op2   = 2'b10;
            end
            7'b0100011: begin
                dec_ok    = (funct3 == 3'b010);
                dec_state = S_ADDR;
                dec_op2   = 2'b11;
                dec_store = 1'b1;
            end
            7'b1100011: begin
                dec_ok    = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec_state = S_BR;
                dec_bne   = funct3[0];
            end
            7'b1101111: begin
                dec_ok    = 1'b1;
                dec_state = S_JAL;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_oe     = 1'b0;
        pc_en      = 1'b0;
        pc_in_dir  = 2'b00;
        pc_sign    = 1'b0;
        ir_en      = 1'b0;
        reg_en     = 1'b0;
        reg_we     = 1'b0;
        reg_in_dir = 2'b00;
        alu_en     = 1'b0;
        alu_op     = OP_ADD;
        op2_dir    = 2'b00;
        state_d    = state_q;
        wait_d     = '0;
        trap_d     = trap_q;
        cause_d    = cause_q;
        op_d       = op_q;
        op2_d      = op2_q;
        store_d    = store_q;
        bne_d      = bne_q;

        case (state_q)
            S_PREPARE: state_d = S_FETCH;
            S_FETCH: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
                if (ram_ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d    = dec_op;
                op2_d   = dec_op2;
                store_d = dec_store;
                bne_d   = dec_bne;
                if (dec_ok) begin
                    state_d = dec_state;
                end else if (TRAP_ON_ILLEGAL != 0) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_en  = 1'b1;
                alu_op  = op_q;
                op2_dir = op2_q;
                state_d = S_WB;
            end
            S_WB: begin
                reg_en     = 1'b1;
                reg_we     = 1'b1;
                reg_in_dir = 2'b10;
                state_d    = S_FETCH;
            end
            S_ADDR: begin
                alu_en  = 1'b1;
                alu_op  = OP_ADD;
                op2_dir = op2_q;
                state_d = S_MEM;
            end
            S_MEM: begin
                ram_cs = 1'b1;
                ram_oe = ~store_q;
                ram_we = store_q;
                if (ram_ready) begin
                    state_d = store_q ? S_FETCH : S_MEMWB;
                end else if (timeout_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_BUS;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_MEMWB: begin
                reg_en     = 1'b1;
                reg_we     = 1'b1;
                reg_in_dir = 2'b00;
                state_d    = S_FETCH;
            end
            S_BR: begin
                alu_en  = 1'b1;
                alu_op  = OP_SUB;
                op2_dir = 2'b00;
                state_d = S_BRDONE;
            end
            S_BRDONE: begin
                // BEQ takes on zero, BNE on non-zero: the xor folds both.
                if (bne_q ^ alu_zero) begin
                    pc_en     = 1'b1;
                    pc_in_dir = 2'b01;
                    pc_sign   = instr[31];
                end
                state_d = S_FETCH;
            end
            S_JAL: begin
                reg_en     = 1'b1;
                reg_we     = 1'b1;
                reg_in_dir = 2'b01;
                pc_en      = 1'b1;
                pc_in_dir  = 2'b01;
                pc_sign    = instr[31];
                state_d    = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_PREPARE;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PREPARE;
            wait_q  <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Decoded instruction attributes are only consumed after DECODE has loaded them.
    always_ff @(posedge clk) begin
        op_q    <= op_d;
        op2_q   <= op2_d;
        store_q <= store_d;
        bne_q   <= bne_d;
    end

endmodule

// File: tb/tb_ctrl_mc.sv
// Directed bench for ctrl_mc: three instances cover default build and HAS_M=0
// with trap-on-illegal enabled and disabled.
module tb_ctrl_mc;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        ram_ready;
    logic        alu_zero;

    logic       m_cs, m_we, m_oe, m_pcen, m_sign, m_ir, m_ren, m_rwe, m_alu, m_tr;
    logic [1:0] m_pcdir, m_rdir, m_op2, m_cause;
    logic [7:0] m_op;
    logic       a_cs, a_we, a_oe, a_pcen, a_sign, a_ir, a_ren, a_rwe, a_alu, a_tr;
    logic [1:0] a_pcdir, a_rdir, a_op2, a_cause;
    logic [7:0] a_op;
    logic       b_cs, b_we, b_oe, b_pcen, b_sign, b_ir, b_ren, b_rwe, b_alu, b_tr;
    logic [1:0] b_pcdir, b_rdir, b_op2, b_cause;
    logic [7:0] b_op;

    logic [25:0] m_obs, a_obs, b_obs;
    assign m_obs = {m_cs, m_we, m_oe, m_pcen, m_pcdir, m_sign, m_ir, m_ren, m_rwe, m_rdir, m_alu, m_op, m_op2, m_tr, m_cause};
    assign a_obs = {a_cs, a_we, a_oe, a_pcen, a_pcdir, a_sign, a_ir, a_ren, a_rwe, a_rdir, a_alu, a_op, a_op2, a_tr, a_cause};
    assign b_obs = {b_cs, b_we, b_oe, b_pcen, b_pcdir, b_sign, b_ir, b_ren, b_rwe, b_rdir, b_alu, b_op, b_op2, b_tr, b_cause};

    ctrl_mc dut (
        .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_zero(alu_zero),
        .ram_cs(m_cs), .ram_we(m_we), .ram_oe(m_oe), .pc_en(m_pcen), .pc_in_dir(m_pcdir),
        .pc_sign(m_sign), .ir_en(m_ir), .reg_en(m_ren), .reg_we(m_rwe), .reg_in_dir(m_rdir),
        .alu_en(m_alu), .alu_op(m_op), .op2_dir(m_op2), .trap(m_tr), .trap_cause(m_cause)
    );

    ctrl_mc #(.HAS_M(0), .TRAP_ON_ILLEGAL(1)) dut_a (
        .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_zero(alu_zero),
        .ram_cs(a_cs), .ram_we(a_we), .ram_oe(a_oe), .pc_en(a_pcen), .pc_in_dir(a_pcdir),
        .pc_sign(a_sign), .ir_en(a_ir), .reg_en(a_ren), .reg_we(a_rwe), .reg_in_dir(a_rdir),
        .alu_en(a_alu), .alu_op(a_op), .op2_dir(a_op2), .trap(a_tr), .trap_cause(a_cause)
    );

    ctrl_mc #(.HAS_M(0), .TRAP_ON_ILLEGAL(0)) dut_b (
        .clk(clk), .rst(rst), .instr(instr), .ram_ready(ram_ready), .alu_zero(alu_zero),
        .ram_cs(b_cs), .ram_we(b_we), .ram_oe(b_oe), .pc_en(b_pcen), .pc_in_dir(b_pcdir),
        .pc_sign(b_sign), .ir_en(b_ir), .reg_en(b_ren), .reg_we(b_rwe), .reg_in_dir(b_rdir),
        .alu_en(b_alu), .alu_op(b_op), .op2_dir(b_op2), .trap(b_tr), .trap_cause(b_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic logic [25:0] mk(input logic cs, input logic we, input logic oe,
                                       input logic pcen, input logic [1:0] pcdir,
                                       input logic sign, input logic ir, input logic ren,
                                       input logic rwe, input logic [1:0] rdir,
                                       input logic alu, input logic [7:0] op,
                                       input logic [1:0] op2, input logic tr,
                                       input logic [1:0] cause);
        return {cs, we, oe, pcen, pcdir, sign, ir, ren, rwe, rdir, alu, op, op2, tr, cause};
    endfunction

    task automatic chk(input string tag, input logic [25:0] o, input logic [25:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_LW  = 32'h0080A283;
    localparam logic [31:0] I_SW  = 32'h0020A423;
    localparam logic [31:0] I_BEQ = 32'h00208463;
    localparam logic [31:0] I_JAL = 32'hFFDFF0EF;
    localparam logic [31:0] I_MUL = 32'h022081B3;
    localparam logic [31:0] I_BAD = 32'h00000000;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [25:0] zero, f_rdy, f_wait, wb, t_bus, t_ill;
        zero   = '0;
        f_rdy  = mk(1, 0, 1, 1, 2'b00, 0, 1, 0, 0, 2'b00, 0, 8'd0, 2'b00, 0, 2'b00);
        f_wait = mk(1, 0, 1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'b00, 0, 2'b00);
        wb     = mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b10, 0, 8'd0, 2'b00, 0, 2'b00);
        t_bus  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'b00, 1, 2'b10);
        t_ill  = mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'b00, 1, 2'b01);

        rst = 1'b1; instr = I_ADD; ram_ready = 1'b1; alu_zero = 1'b0;
        tick(); tick();
        chk("reset_state", m_obs, zero);
        rst = 1'b0;

        // ADD x3,x1,x2
        tick(); chk("add_fetch", m_obs, f_rdy);
        tick(); chk("add_decode", m_obs, zero);
        tick(); chk("add_exec", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd0, 2'b00, 0, 2'b00));
        tick(); chk("add_wb", m_obs, wb);
        tick(); chk("add_next_fetch", m_obs, f_rdy);

        // LW x5,8(x1) with three stalled MEM cycles
        instr = I_LW;
        tick(); chk("lw_decode", m_obs, zero);
        tick(); chk("lw_addr", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd0, 2'b10, 0, 2'b00));
        ram_ready = 1'b0;
        tick(); chk("lw_mem_wait1", m_obs, f_wait);
        tick(); chk("lw_mem_wait2", m_obs, f_wait);
        tick(); chk("lw_mem_wait3", m_obs, f_wait);
        ram_ready = 1'b1; #1;
        chk("lw_mem_ready", m_obs, f_wait);
        tick(); chk("lw_memwb", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 2'b00, 0, 8'd0, 2'b00, 0, 2'b00));
        tick(); chk("lw_next_fetch", m_obs, f_rdy);

        // BEQ taken
        instr = I_BEQ;
        tick(); chk("beq_t_decode", m_obs, zero);
        tick(); chk("beq_t_br", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd2, 2'b00, 0, 2'b00));
        alu_zero = 1'b1;
        tick(); chk("beq_t_brdone", m_obs, mk(0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'b00, 0, 2'b00));
        tick(); chk("beq_t_fetch", m_obs, f_rdy);
        // BEQ not taken
        tick(); chk("beq_n_decode", m_obs, zero);
        tick(); chk("beq_n_br", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd2, 2'b00, 0, 2'b00));
        alu_zero = 1'b0;
        tick(); chk("beq_n_brdone", m_obs, zero);
        tick(); chk("beq_n_fetch", m_obs, f_rdy);

        // JAL x1,-4 (negative offset drives pc_sign)
        instr = I_JAL;
        tick(); chk("jal_decode", m_obs, zero);
        tick(); chk("jal_state", m_obs, mk(0, 0, 0, 1, 2'b01, 1, 0, 1, 1, 2'b01, 0, 8'd0, 2'b00, 0, 2'b00));
        tick(); chk("jal_fetch", m_obs, f_rdy);

        // SW x2,8(x1)
        instr = I_SW;
        tick(); chk("sw_decode", m_obs, zero);
        tick(); chk("sw_addr", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd0, 2'b11, 0, 2'b00));
        tick(); chk("sw_mem", m_obs, mk(1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 8'd0, 2'b00, 0, 2'b00));
        tick(); chk("sw_fetch", m_obs, f_rdy);

        // rst asserted while in EXEC
        instr = I_ADD;
        tick(); chk("rx_decode", m_obs, zero);
        tick(); chk("rx_exec", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd0, 2'b00, 0, 2'b00));
        rst = 1'b1;
        tick(); chk("rx_after_rst", m_obs, zero);
        rst = 1'b0;
        tick(); chk("rx_fetch", m_obs, f_rdy);

        // Fetch timeout into bus-error trap
        rst = 1'b1;
        tick();
        rst = 1'b0; ram_ready = 1'b0;
        tick(); chk("to_fetch_w0", m_obs, f_wait);
        for (int i = 1; i <= 15; i++) begin
            tick(); chk($sformatf("to_fetch_w%0d", i), m_obs, f_wait);
        end
        tick(); chk("to_trap", m_obs, t_bus);
        ram_ready = 1'b1;
        tick(); chk("to_trap_hold1", m_obs, t_bus);
        tick(); chk("to_trap_hold2", m_obs, t_bus);

        // ram_ready arriving exactly at the limit is a successful fetch
        rst = 1'b1; ram_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 1; i <= 15; i++) tick();
        ram_ready = 1'b1; #1;
        chk("lim_ready", m_obs, f_rdy);
        tick(); chk("lim_decode", m_obs, zero);

        // MUL on all three builds
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; ram_ready = 1'b1; instr = I_MUL;
        chk("mul_rst_a", a_obs, zero);
        chk("mul_rst_b", b_obs, zero);
        tick();
        chk("mul_fetch_m", m_obs, f_rdy);
        chk("mul_fetch_a", a_obs, f_rdy);
        chk("mul_fetch_b", b_obs, f_rdy);
        tick();
        chk("mul_decode_a", a_obs, zero);
        chk("mul_decode_b", b_obs, zero);
        tick();
        chk("mul_exec_m", m_obs, mk(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 8'd3, 2'b00, 0, 2'b00));
        chk("mul_trap_a", a_obs, t_ill);
        chk("mul_skip_b", b_obs, f_rdy);
        tick();
        chk("mul_wb_m", m_obs, wb);
        chk("mul_trap_hold_a", a_obs, t_ill);
        chk("mul_redecode_b", b_obs, zero);

        // Illegal opcode on the default build
        instr = I_BAD;
        tick(); chk("ill_fetch_m", m_obs, f_rdy);
        tick(); chk("ill_decode_m", m_obs, zero);
        tick(); chk("ill_trap_m", m_obs, t_ill);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
